// File: rtl/dsp_mac_array.sv
// dsp_mac_array: G_SIZE lanes of signed multiply-accumulate in the style of a DSP48 slice
// (AREG input stages, MREG multiplier stages, one P accumulator stage) sharing a single
// valid/ready control path with a global output stall.
// Build option: define DSP_SAT_EN for saturating MACC sums and a sticky per-lane OVF flag;
// without it sums wrap modulo 2^P_W and OVF is tied to zero.
module dsp_mac_array #(
  parameter int unsigned G_SIZE = 4,
  parameter int unsigned A_W    = 25,
  parameter int unsigned B_W    = 18,
  parameter int unsigned P_W    = 48,
  parameter int unsigned AREG   = 2,
  parameter int unsigned MREG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            OPMODE,
  input  logic [G_SIZE*A_W-1:0] A,
  input  logic [G_SIZE*B_W-1:0] B,
  input  logic [G_SIZE*P_W-1:0] C,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [G_SIZE*P_W-1:0] P,
  output logic [G_SIZE-1:0]     OVF
);

  localparam int unsigned M_W  = A_W + B_W;
  localparam int unsigned AT_W = G_SIZE * A_W;
  localparam int unsigned BT_W = G_SIZE * B_W;
  localparam int unsigned PT_W = G_SIZE * P_W;
  localparam int unsigned MT_W = G_SIZE * M_W;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MACC = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  // ---------------------------------------------------------------------------
  // Shared control: a held output beat freezes the entire pipeline.
  // ---------------------------------------------------------------------------
  logic stall_c;
  logic in_fire_c;
  logic out_valid_q;
  logic out_valid_d;

  assign stall_c   = out_valid_q && !OUT_READY;
  assign IN_READY  = !stall_c;
  assign in_fire_c = IN_VALID && !stall_c;

  // ---------------------------------------------------------------------------
  // Input register chain. Element 0 is the port side, element AREG feeds the
  // multiplier; with AREG = 0 the ports feed the multiplier directly.
  // ---------------------------------------------------------------------------
  logic            st_v  [AREG+1];
  logic [1:0]      st_op [AREG+1];
  logic [AT_W-1:0] st_a  [AREG+1];
  logic [BT_W-1:0] st_b  [AREG+1];
  logic [PT_W-1:0] st_c  [AREG+1];

  assign st_v[0]  = in_fire_c;
  assign st_op[0] = OPMODE;
  assign st_a[0]  = A;
  assign st_b[0]  = B;
  assign st_c[0]  = C;

  for (genvar k = 0; k < AREG; k++) begin : g_areg
    logic            v_q;
    logic [1:0]      op_q;
    logic [AT_W-1:0] a_q;
    logic [BT_W-1:0] b_q;
    logic [PT_W-1:0] c_q;

    // Stage valid: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge CLK) begin
      if (RST) begin
        v_q <= 1'b0;
      end else if (!stall_c) begin
        v_q <= st_v[k];
      end
    end

    // Stage payload: only meaningful alongside v_q, so no reset needed.
    always_ff @(posedge CLK) begin
      if (!stall_c) begin
        op_q <= st_op[k];
        a_q  <= st_a[k];
        b_q  <= st_b[k];
        c_q  <= st_c[k];
      end
    end

    assign st_v[k+1]  = v_q;
    assign st_op[k+1] = op_q;
    assign st_a[k+1]  = a_q;
    assign st_b[k+1]  = b_q;
    assign st_c[k+1]  = c_q;
  end

  // ---------------------------------------------------------------------------
  // Full-width signed products, one per lane.
  // ---------------------------------------------------------------------------
  logic [MT_W-1:0] mul_c;

  for (genvar i = 0; i < G_SIZE; i++) begin : g_mul
    logic signed [A_W-1:0] a_l;
    logic signed [B_W-1:0] b_l;

    assign a_l = st_a[AREG][i*A_W +: A_W];
    assign b_l = st_b[AREG][i*B_W +: B_W];
    assign mul_c[i*M_W +: M_W] = M_W'(a_l) * M_W'(b_l);
  end

  // ---------------------------------------------------------------------------
  // Multiplier register chain; C and OPMODE ride along with the product.
  // ---------------------------------------------------------------------------
  logic            ms_v    [MREG+1];
  logic [1:0]      ms_op   [MREG+1];
  logic [MT_W-1:0] ms_prod [MREG+1];
  logic [PT_W-1:0] ms_c    [MREG+1];

  assign ms_v[0]    = st_v[AREG];
  assign ms_op[0]   = st_op[AREG];
  assign ms_prod[0] = mul_c;
  assign ms_c[0]    = st_c[AREG];

  for (genvar k = 0; k < MREG; k++) begin : g_mreg
    logic            v_q;
    logic [1:0]      op_q;
    logic [MT_W-1:0] prod_q;
    logic [PT_W-1:0] c_q;

    // Stage valid: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge CLK) begin
      if (RST) begin
        v_q <= 1'b0;
      end else if (!stall_c) begin
        v_q <= ms_v[k];
      end
    end

    // Stage payload: product, load value and operation.
    always_ff @(posedge CLK) begin
      if (!stall_c) begin
        op_q   <= ms_op[k];
        prod_q <= ms_prod[k];
        c_q    <= ms_c[k];
      end
    end

    assign ms_v[k+1]    = v_q;
    assign ms_op[k+1]   = op_q;
    assign ms_prod[k+1] = prod_q;
    assign ms_c[k+1]    = c_q;
  end

  logic            fin_v;
  logic [1:0]      fin_op;
  logic [MT_W-1:0] fin_prod;
  logic [PT_W-1:0] fin_c;
  logic            p_en_c;

  assign fin_v    = ms_v[MREG];
  assign fin_op   = ms_op[MREG];
  assign fin_prod = ms_prod[MREG];
  assign fin_c    = ms_c[MREG];
  assign p_en_c   = fin_v && !stall_c;

  // Output valid: follows the final stage whenever the pipeline advances.
  always_comb begin
    out_valid_d = out_valid_q;
    if (!stall_c) begin
      out_valid_d = fin_v;
    end
  end

  // Output valid register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_VALID = out_valid_q;

`ifdef DSP_SAT_EN
  localparam logic [P_W-1:0] SAT_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] SAT_MIN = {1'b1, {(P_W-1){1'b0}}};
`endif

  // ---------------------------------------------------------------------------
  // P accumulator per lane. MACC reads p_q directly, so the beat immediately
  // ahead is already folded in for back-to-back accumulation.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < G_SIZE; i++) begin : g_lane
    logic signed [M_W-1:0] prod_l;
    logic signed [P_W-1:0] prod_ext_c;
    logic signed [P_W-1:0] c_l;
    logic signed [P_W-1:0] sum_c;
    logic signed [P_W-1:0] p_q;
    logic signed [P_W-1:0] p_d;

    assign prod_l     = fin_prod[i*M_W +: M_W];
    assign prod_ext_c = P_W'(prod_l);
    assign c_l        = fin_c[i*P_W +: P_W];
    assign sum_c      = p_q + prod_ext_c;

`ifdef DSP_SAT_EN
    logic ovf_q;
    logic ovf_d;
    logic add_ovf_c;

    // Signed overflow: operands agree in sign but the sum does not.
    assign add_ovf_c = (p_q[P_W-1] == prod_ext_c[P_W-1]) && (sum_c[P_W-1] != p_q[P_W-1]);

    // Lane next state: saturating MACC, sticky OVF cleared only by LOAD.
    always_comb begin
      p_d   = p_q;
      ovf_d = ovf_q;
      if (p_en_c) begin
        case (fin_op)
          OP_MUL:  p_d = prod_ext_c;
          OP_MACC: begin
            if (add_ovf_c) begin
              p_d   = p_q[P_W-1] ? SAT_MIN : SAT_MAX;
              ovf_d = 1'b1;
            end else begin
              p_d = sum_c;
            end
          end
          OP_LOAD: begin
            p_d   = c_l;
            ovf_d = 1'b0;
          end
          default: p_d = p_q;
        endcase
      end
    end

    // Lane accumulator and overflow flag.
    always_ff @(posedge CLK) begin
      if (RST) begin
        p_q   <= '0;
        ovf_q <= 1'b0;
      end else begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end

    assign OVF[i] = ovf_q;
`else
    // Lane next state: wrapping MACC.
    always_comb begin
      p_d = p_q;
      if (p_en_c) begin
        case (fin_op)
          OP_MUL:  p_d = prod_ext_c;
          OP_MACC: p_d = sum_c;
          OP_LOAD: p_d = c_l;
          default: p_d = p_q;
        endcase
      end
    end

    // Lane accumulator.
    always_ff @(posedge CLK) begin
      if (RST) begin
        p_q <= '0;
      end else begin
        p_q <= p_d;
      end
    end

    assign OVF[i] = 1'b0;
`endif

    assign P[i*P_W +: P_W] = p_q;
  end

endmodule

// File: tb/tb_dsp_mac_array.sv
// Scoreboard bench for dsp_mac_array: a beat-level reference model predicts each lane's
// accumulator on every accepted input; a negedge monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_dsp_mac_array #(
  parameter int unsigned G_SIZE = 4,
  parameter int unsigned A_W    = 25,
  parameter int unsigned B_W    = 18,
  parameter int unsigned P_W    = 48,
  parameter int unsigned AREG   = 2,
  parameter int unsigned MREG   = 1
);
  localparam int          L  = int'(AREG + MREG + 1);
  localparam int unsigned AT = G_SIZE * A_W;
  localparam int unsigned BT = G_SIZE * B_W;
  localparam int unsigned PT = G_SIZE * P_W;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MACC = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        opmode;
  logic [AT-1:0]     a;
  logic [BT-1:0]     b;
  logic [PT-1:0]     c;
  logic              out_valid;
  logic              out_ready;
  logic [PT-1:0]     p;
  logic [G_SIZE-1:0] ovf;

  dsp_mac_array #(
    .G_SIZE(G_SIZE), .A_W(A_W), .B_W(B_W), .P_W(P_W), .AREG(AREG), .MREG(MREG)
  ) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .OPMODE(opmode),
    .A(a), .B(b), .C(c), .OUT_VALID(out_valid), .OUT_READY(out_ready), .P(p), .OVF(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PT-1:0]     p;
    logic [G_SIZE-1:0] ovf;
    int                dec;
    bit                lat;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  longint            acc [G_SIZE];
  logic [G_SIZE-1:0] ovf_m;
  int                n_chk = 0;
  int                n_pass = 0;
  int                cyc = 0;
  bit                lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event did not occur as required at t=%0t", nm, $time);
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Reference model: apply one accepted beat to every lane, queue the expected output.
  task automatic model_beat(input logic [1:0] op, input logic [AT-1:0] av,
                            input logic [BT-1:0] bv, input logic [PT-1:0] cv, input int dec);
    exp_t   e;
    longint pmax;
    longint pmin;
    pmax = (longint'(1) <<< (P_W - 1)) - 1;
    pmin = -pmax - 1;
    for (int l = 0; l < int'(G_SIZE); l++) begin
      longint prod;
      longint s;
      prod = sx(64'(av[l*A_W +: A_W]), A_W) * sx(64'(bv[l*B_W +: B_W]), B_W);
      s    = acc[l] + prod;
      case (op)
        OP_MUL:  acc[l] = prod;
        OP_MACC: begin
`ifdef DSP_SAT_EN
          if (s > pmax) begin
            acc[l] = pmax; ovf_m[l] = 1'b1;
          end else if (s < pmin) begin
            acc[l] = pmin; ovf_m[l] = 1'b1;
          end else begin
            acc[l] = s;
          end
`else
          acc[l] = sx(64'(s), P_W);
`endif
        end
        OP_LOAD: begin
          acc[l]   = sx(64'(cv[l*P_W +: P_W]), P_W);
          ovf_m[l] = 1'b0;
        end
        default: ;
      endcase
      e.p[l*P_W +: P_W] = P_W'(acc[l]);
    end
    e.ovf = ovf_m;
    e.dec = dec;
    e.lat = lat_chk;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the presented beat with the queue head; retire it on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_out");
        end else begin
          mon_e = exp_q[0];
          for (int l = 0; l < int'(G_SIZE); l++)
            chk($sformatf("p_lane%0d", l), 64'(p[l*P_W +: P_W]), 64'(mon_e.p[l*P_W +: P_W]));
          chk("ovf", 64'(ovf), 64'(mon_e.ovf));
          if (out_ready) begin
            if (mon_e.lat) chk("latency", 64'(cyc - mon_e.dec), 64'(L));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Offer one beat (called at posedge+1); waits, bounded, until it is accepted.
  task automatic send(input logic [1:0] op, input logic [AT-1:0] av,
                      input logic [BT-1:0] bv, input logic [PT-1:0] cv);
    int w = 0;
    in_valid = 1'b1; opmode = op; a = av; b = bv; c = cv;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (in_ready) model_beat(op, av, bv, cv, cyc);
    else fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(output logic [AT-1:0] av, output logic [BT-1:0] bv,
                          output logic [PT-1:0] cv);
    for (int l = 0; l < int'(G_SIZE); l++) begin
      if ($urandom_range(0, 2) == 0) begin
        av[l*A_W +: A_W] = A_W'(int'($urandom_range(0, 15)) - 8);
        bv[l*B_W +: B_W] = B_W'(int'($urandom_range(0, 15)) - 8);
      end else begin
        av[l*A_W +: A_W] = A_W'($urandom());
        bv[l*B_W +: B_W] = B_W'($urandom());
      end
      cv[l*P_W +: P_W] = P_W'({$urandom(), $urandom()});
    end
  endtask

  // Reset pulse (optionally with a beat offered in the same cycle), then check idle state.
  task automatic do_reset(input bit with_beat);
    logic [AT-1:0] av;
    logic [BT-1:0] bv;
    logic [PT-1:0] cv;
    rst = 1'b1;
    if (with_beat) begin
      rand_ops(av, bv, cv);
      in_valid = 1'b1; opmode = OP_LOAD; a = av; b = bv; c = cv;
    end
    @(negedge clk);
    exp_q.delete();
    for (int l = 0; l < int'(G_SIZE); l++) acc[l] = 0;
    ovf_m = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (L + 1) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      for (int l = 0; l < int'(G_SIZE); l++)
        chk($sformatf("rst_p_lane%0d", l), 64'(p[l*P_W +: P_W]), 64'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AT-1:0] av;
    logic [BT-1:0] bv;
    logic [PT-1:0] cv;
    logic [AT-1:0] zero_a;
    logic [BT-1:0] zero_b;
    logic [PT-1:0] zero_c;
    bit            done;
    zero_a = '0; zero_b = '0; zero_c = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opmode = OP_MUL;
    a = '0; b = '0; c = '0; ovf_m = '0;
    for (int l = 0; l < int'(G_SIZE); l++) acc[l] = 0;
    idle(2);
    do_reset(1'b0);

    // Single MUL: lane0 3 * -5, other lanes zero.
    lat_chk = 1'b1;
    av = zero_a; bv = zero_b;
    av[0 +: A_W] = A_W'(3);
    bv[0 +: B_W] = B_W'(-5);
    send(OP_MUL, av, bv, zero_c);
    idle(L + 2);

    // LOAD 100 then three back-to-back MACC 2*7 on lane0.
    cv = zero_c;
    cv[0 +: P_W] = P_W'(100);
    send(OP_LOAD, zero_a, zero_b, cv);
    av = zero_a; bv = zero_b;
    av[0 +: A_W] = A_W'(2);
    bv[0 +: B_W] = B_W'(7);
    repeat (3) send(OP_MACC, av, bv, zero_c);
    send(OP_HOLD, av, bv, zero_c);
    drain();

    // Backpressure: consumer stalls 5 cycles while 6 beats are offered.
    lat_chk = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          rand_ops(av, bv, cv);
          send(2'($urandom_range(0, 3)), av, bv, cv);
        end
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight; a beat offered during reset is dropped.
    lat_chk = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rand_ops(av, bv, cv);
      send(OP_LOAD, av, bv, cv);
    end
    do_reset(1'b1);
    av = zero_a; bv = zero_b;
    av[0 +: A_W] = A_W'(3);
    bv[0 +: B_W] = B_W'(4);
    send(OP_MACC, av, bv, zero_c);
    drain();

    // Overflow corners on lane0: positive and negative saturation (or wrap).
    cv = zero_c;
    cv[0 +: P_W] = P_W'((longint'(1) <<< (P_W - 1)) - 10);
    send(OP_LOAD, zero_a, zero_b, cv);
    av = zero_a; bv = zero_b;
    av[0 +: A_W] = A_W'(4);
    bv[0 +: B_W] = B_W'(4);
    send(OP_MACC, av, bv, zero_c);
    av[0 +: A_W] = A_W'(1);
    bv[0 +: B_W] = B_W'(1);
    send(OP_MACC, av, bv, zero_c);
    av[0 +: A_W] = A_W'(2);
    bv[0 +: B_W] = B_W'(3);
    send(OP_MUL, av, bv, zero_c);
    send(OP_LOAD, zero_a, zero_b, zero_c);
    cv[0 +: P_W] = P_W'(-(longint'(1) <<< (P_W - 1)) + 5);
    send(OP_LOAD, zero_a, zero_b, cv);
    av[0 +: A_W] = A_W'(-4);
    bv[0 +: B_W] = B_W'(4);
    send(OP_MACC, av, bv, zero_c);
    send(OP_LOAD, zero_a, zero_b, zero_c);
    drain();

    // Random beats under random backpressure.
    lat_chk = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          rand_ops(av, bv, cv);
          send(2'($urandom_range(0, 3)), av, bv, cv);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random beats without backpressure: latency checked per beat.
    lat_chk = 1'b1;
    for (int n = 0; n < 100; n++) begin
      rand_ops(av, bv, cv);
      send(2'($urandom_range(0, 3)), av, bv, cv);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
